// File: rtl/sal_cmd_sched.sv
// Command scheduler at the destination end of the bank-controller interface: one grant per cycle
// across NUM_BANKS banks with class priority, round-robin fairness and inter-bank timing spacing.
module sal_cmd_sched #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned T_W       = 8,
  parameter int unsigned RA_W      = 16,
  parameter int unsigned CA_W      = 10,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned LEN_W     = 8,
  localparam int unsigned BA_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_BANKS-1:0]        act_req,
  input  logic [NUM_BANKS-1:0]        rd_req,
  input  logic [NUM_BANKS-1:0]        wr_req,
  input  logic [NUM_BANKS-1:0]        pre_req,
  input  logic [NUM_BANKS-1:0]        ref_req,
  input  logic [NUM_BANKS*BA_W-1:0]   ba_i,
  input  logic [NUM_BANKS*RA_W-1:0]   ra_i,
  input  logic [NUM_BANKS*CA_W-1:0]   ca_i,
  input  logic [NUM_BANKS*ID_W-1:0]   id_i,
  input  logic [NUM_BANKS*LEN_W-1:0]  len_i,
  output logic [NUM_BANKS-1:0]        act_gnt,
  output logic [NUM_BANKS-1:0]        rd_gnt,
  output logic [NUM_BANKS-1:0]        wr_gnt,
  output logic [NUM_BANKS-1:0]        pre_gnt,
  output logic [NUM_BANKS-1:0]        ref_gnt,
  input  logic [T_W-1:0]              t_rrd_m1,
  input  logic [T_W-1:0]              t_ccd_m1,
  input  logic [T_W-1:0]              t_wtr_m1,
  input  logic [T_W-1:0]              t_rtw_m1,
  output logic                        cmd_valid,
  output logic [2:0]                  cmd_type,
  output logic [BA_W-1:0]             cmd_ba,
  output logic [RA_W-1:0]             cmd_ra,
  output logic [CA_W-1:0]             cmd_ca,
  output logic [ID_W-1:0]             cmd_id,
  output logic [LEN_W-1:0]            cmd_len
);

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    CLS_REF = 2'd0,
    CLS_CAS = 2'd1,
    CLS_ACT = 2'd2,
    CLS_PRE = 2'd3
  } cls_e;

  logic [CNT_W-1:0]     r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;
  logic [BA_W-1:0]      r_rr_ptr;
  logic                 r_cmd_valid;
  cmd_e                 r_cmd_type;
  logic [BA_W-1:0]      r_cmd_ba;
  logic [RA_W-1:0]      r_cmd_ra;
  logic [CA_W-1:0]      r_cmd_ca;
  logic [ID_W-1:0]      r_cmd_id;
  logic [LEN_W-1:0]     r_cmd_len;

  logic [NUM_BANKS-1:0] w_rd_elig, w_wr_elig, w_cas_elig, w_act_elig, w_cand, w_gnt_oh;
  logic                 w_rd_ok, w_wr_ok, w_found, w_gnt_any;
  cls_e                 w_cls;
  cmd_e                 w_cmd_type;
  logic [BA_W-1:0]      w_bank, w_rr_next;
  logic                 w_act_fire, w_rd_fire, w_wr_fire;

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  // Eligibility per class; a bank raising rd and wr together is treated as RD only
  always_comb begin
    w_rd_ok    = (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
    w_wr_ok    = (r_ccd_cnt == '0) && (r_rtw_cnt == '0);
    w_rd_elig  = rd_req & {NUM_BANKS{w_rd_ok}};
    w_wr_elig  = wr_req & ~rd_req & {NUM_BANKS{w_wr_ok}};
    w_cas_elig = w_rd_elig | w_wr_elig;
    w_act_elig = act_req & {NUM_BANKS{r_rrd_cnt == '0}};
  end

  // Highest class with an eligible requester, then round-robin from r_rr_ptr
  always_comb begin
    int unsigned k;
    w_cls   = CLS_PRE;
    w_cand  = pre_req;
    w_found = 1'b0;
    w_bank  = '0;
    k       = 0;
    if (|ref_req) begin
      w_cls  = CLS_REF;
      w_cand = ref_req;
    end else if (|w_cas_elig) begin
      w_cls  = CLS_CAS;
      w_cand = w_cas_elig;
    end else if (|w_act_elig) begin
      w_cls  = CLS_ACT;
      w_cand = w_act_elig;
    end
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      k = (32'(r_rr_ptr) + i) % NUM_BANKS;
      if (!w_found && w_cand[k]) begin
        w_found = 1'b1;
        w_bank  = BA_W'(k);
      end
    end
  end

  // One-hot grant decode, suppressed while reset is asserted
  always_comb begin
    w_gnt_any = rst_n && w_found;
    w_gnt_oh  = '0;
    if (w_gnt_any) w_gnt_oh[w_bank] = 1'b1;
    ref_gnt    = (w_cls == CLS_REF) ? w_gnt_oh : '0;
    rd_gnt     = (w_cls == CLS_CAS) ? (w_gnt_oh & w_rd_elig) : '0;
    wr_gnt     = (w_cls == CLS_CAS) ? (w_gnt_oh & w_wr_elig) : '0;
    act_gnt    = (w_cls == CLS_ACT) ? w_gnt_oh : '0;
    pre_gnt    = (w_cls == CLS_PRE) ? w_gnt_oh : '0;
    w_act_fire = |act_gnt;
    w_rd_fire  = |rd_gnt;
    w_wr_fire  = |wr_gnt;
    w_rr_next  = (w_bank == BA_W'(NUM_BANKS - 1)) ? '0 : w_bank + BA_W'(1);
    w_cmd_type = CMD_NOP;
    if (w_gnt_any) begin
      unique case (w_cls)
        CLS_REF: w_cmd_type = CMD_REF;
        CLS_CAS: w_cmd_type = w_rd_fire ? CMD_RD : CMD_WR;
        CLS_ACT: w_cmd_type = CMD_ACT;
        default: w_cmd_type = CMD_PRE;
      endcase
    end
  end

  // Timing counters: reload on the matching grant, otherwise count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrd_cnt <= '0;
      r_ccd_cnt <= '0;
      r_wtr_cnt <= '0;
      r_rtw_cnt <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_rrd_cnt <= w_act_fire ? CNT_W'(t_rrd_m1) : dec_sat(r_rrd_cnt);
      r_ccd_cnt <= (w_rd_fire || w_wr_fire) ? CNT_W'(t_ccd_m1) : dec_sat(r_ccd_cnt);
      r_rtw_cnt <= w_rd_fire ? CNT_W'(t_rtw_m1) : dec_sat(r_rtw_cnt);
      r_wtr_cnt <= w_wr_fire ? CNT_W'(t_wtr_m1) : dec_sat(r_wtr_cnt);
      if (w_gnt_any) r_rr_ptr <= w_rr_next;
    end
  end

  // Registered command toward the PHY; fields hold when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= CMD_NOP;
      r_cmd_ba    <= '0;
      r_cmd_ra    <= '0;
      r_cmd_ca    <= '0;
      r_cmd_id    <= '0;
      r_cmd_len   <= '0;
    end else begin
      r_cmd_valid <= w_gnt_any;
      r_cmd_type  <= w_cmd_type;
      if (w_gnt_any) begin
        r_cmd_ba  <= ba_i[32'(w_bank)*BA_W +: BA_W];
        r_cmd_ra  <= ra_i[32'(w_bank)*RA_W +: RA_W];
        r_cmd_ca  <= ca_i[32'(w_bank)*CA_W +: CA_W];
        r_cmd_id  <= id_i[32'(w_bank)*ID_W +: ID_W];
        r_cmd_len <= len_i[32'(w_bank)*LEN_W +: LEN_W];
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_type  = r_cmd_type;
  assign cmd_ba    = r_cmd_ba;
  assign cmd_ra    = r_cmd_ra;
  assign cmd_ca    = r_cmd_ca;
  assign cmd_id    = r_cmd_id;
  assign cmd_len   = r_cmd_len;

  // A bank controller must never ask for RD and WR in the same cycle
  a_no_rd_wr_same_bank: assert property (@(posedge clk) disable iff (!rst_n)
    (rd_req & wr_req) == '0)
    else $warning("bank controller raised rd_req and wr_req together: %b", rd_req & wr_req);

endmodule
